sym_vector_capture: RTL and testbench

SYM_VECTOR_CAPTURE -- requirements
Module: sym_vector_capture

---
 rtl/sym_vector_capture.sv | 237 +++++++++++++++++++++++
 tb/tb_sym_vector_capture.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_vector_capture.sv
// sym_vector_capture
// Drives a pseudo-random byte stream into an external symbol encoder and
// captures the encoder's symbol vectors into a FIFO for later readout.
// A run has three phases: an optional warm-up covering the encoder
// latency, a fixed number of capture cycles, and a drain phase that waits
// for the reader to empty the FIFO.
//
// Optional feature: define SYM_CAPTURE_CHECKSUM_EN to add the io_checksum
// output, a rotate-and-xor signature over every vector accepted into the
// FIFO during the current run.

module sym_vector_capture #(
    parameter int NUM_LANES = 4,
    parameter int SYM_W     = 3,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_start,
    input  logic                       io_abort,
    input  logic [15:0]                io_num_data,
    input  logic [7:0]                 io_skip,
    input  logic [15:0]                io_seed,
    output logic                       io_tx_enable,
    output logic [DATA_W-1:0]          io_tx_data,
    input  logic [NUM_LANES*SYM_W-1:0] io_syms,
    output logic                       io_rd_valid,
    input  logic                       io_rd_ready,
    output logic [NUM_LANES*SYM_W-1:0] io_rd_data,
    output logic                       io_busy,
    output logic                       io_done,
    output logic                       io_overflow
`ifdef SYM_CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0]                io_checksum
`endif
);

    localparam int          VEC_W        = NUM_LANES * SYM_W;
    localparam int          AW           = $clog2(DEPTH);
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Run bookkeeping
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [15:0] count;
    logic [7:0]  skip_cnt;
    logic        launch;

    // Capture FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [VEC_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      ptr_diff;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_last;
    logic             pop;
    logic             wr_en;
    logic             drop;

    // A run is launched only from IDLE, and an abort always wins over start
    assign launch = (state == IDLE) && io_start && !io_abort;

    // Taps x^16 + x^14 + x^13 + x^11 sit on bits 15, 13, 12 and 10
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    assign ptr_diff   = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign fifo_last  = (ptr_diff == {{AW{1'b0}}, 1'b1});

    // Readout never bypasses: a vector becomes visible the cycle after it is written
    assign io_rd_valid = !fifo_empty;
    assign io_rd_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop         = io_rd_valid && io_rd_ready;

    // A full FIFO still accepts a write when the same cycle frees a slot
    assign wr_en = (state == CAPTURE) && !io_abort && (!fifo_full || pop);
    assign drop  = (state == CAPTURE) && !io_abort && fifo_full && !pop;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; DRAIN looks ahead so DONE follows the final pop directly
    always_comb begin
        next_state = state;
        if (io_abort) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (io_start) begin
                        if (io_num_data == 16'd0) begin
                            next_state = DONE;
                        end else if (io_skip != 8'd0) begin
                            next_state = WARMUP;
                        end else begin
                            next_state = CAPTURE;
                        end
                    end
                end
                WARMUP: begin
                    if (skip_cnt <= 8'd1) begin
                        next_state = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (count <= 16'd1) begin
                        next_state = DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty || (pop && fifo_last)) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    next_state = IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Moore outputs; the encoder sees the current LFSR value only while a run feeds it
    always_comb begin
        io_tx_enable = 1'b0;
        io_tx_data   = '0;
        io_busy      = (state != IDLE);
        io_done      = (state == DONE);
        if ((state == WARMUP) || (state == CAPTURE)) begin
            io_tx_enable = 1'b1;
            io_tx_data   = lfsr[DATA_W-1:0];
        end
    end

    // LFSR, vector count and warm-up count: loaded at launch, stepped while feeding the encoder
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr     <= DEFAULT_SEED;
            count    <= 16'd0;
            skip_cnt <= 8'd0;
        end else if (launch) begin
            lfsr     <= (io_seed == 16'd0) ? DEFAULT_SEED : io_seed;
            count    <= io_num_data;
            skip_cnt <= io_skip;
        end else if (!io_abort) begin
            if (state == WARMUP) begin
                lfsr     <= lfsr_next;
                skip_cnt <= skip_cnt - 8'd1;
            end else if (state == CAPTURE) begin
                lfsr  <= lfsr_next;
                count <= count - 16'd1;
            end
        end
    end

    // FIFO pointers; an abort throws away everything captured so far
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (io_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= io_syms;
        end
    end

    // Sticky overflow flag: survives abort and DONE, cleared only by a new run
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_overflow <= 1'b0;
        end else if (launch) begin
            io_overflow <= 1'b0;
        end else if (drop) begin
            io_overflow <= 1'b1;
        end
    end

`ifdef SYM_CAPTURE_CHECKSUM_EN
    logic [15:0] sym_low;

    // The signature always folds in exactly 16 bits of the vector, zero-extended if narrower
    if (VEC_W >= 16) begin : g_sym_wide
        assign sym_low = io_syms[15:0];
    end else begin : g_sym_narrow
        assign sym_low = {{(16 - VEC_W){1'b0}}, io_syms};
    end

    // Rotate-left-and-xor signature over every vector the FIFO accepts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_checksum <= 16'd0;
        end else if (launch) begin
            io_checksum <= 16'd0;
        end else if (wr_en) begin
            io_checksum <= {io_checksum[14:0], io_checksum[15]} ^ sym_low;
        end
    end
`endif

endmodule

// File: tb/tb_sym_vector_capture.sv
// tb_sym_vector_capture
// Self-checking bench for sym_vector_capture built with a 4-entry FIFO so
// that overflow and full-with-read corners are reached quickly. Expected
// behaviour comes from a queue-based reference model: a queue stands in for
// the FIFO, and the LFSR sequence is derived from the polynomial exponents.
// Build with SYM_CAPTURE_CHECKSUM_EN defined to also check io_checksum.

module tb_sym_vector_capture;

    localparam int NL = 4;
    localparam int SW = 3;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int VW = NL * SW;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_start;
    logic          io_abort;
    logic [15:0]   io_num_data;
    logic [7:0]    io_skip;
    logic [15:0]   io_seed;
    logic          io_tx_enable;
    logic [DW-1:0] io_tx_data;
    logic [VW-1:0] io_syms;
    logic          io_rd_valid;
    logic          io_rd_ready;
    logic [VW-1:0] io_rd_data;
    logic          io_busy;
    logic          io_done;
    logic          io_overflow;
`ifdef SYM_CAPTURE_CHECKSUM_EN
    logic [15:0]   io_checksum;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0]   lfsr_m;
    logic [VW-1:0] q_m[$];
    logic          ovf_m;
    logic [15:0]   cs_m;
    logic [DW-1:0] first_tx[3];

    sym_vector_capture #(
        .NUM_LANES(NL),
        .SYM_W    (SW),
        .DATA_W   (DW),
        .DEPTH    (DP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_start    (io_start),
        .io_abort    (io_abort),
        .io_num_data (io_num_data),
        .io_skip     (io_skip),
        .io_seed     (io_seed),
        .io_tx_enable(io_tx_enable),
        .io_tx_data  (io_tx_data),
        .io_syms     (io_syms),
        .io_rd_valid (io_rd_valid),
        .io_rd_ready (io_rd_ready),
        .io_rd_data  (io_rd_data),
        .io_busy     (io_busy),
        .io_done     (io_done),
        .io_overflow (io_overflow)
`ifdef SYM_CAPTURE_CHECKSUM_EN
        ,
        .io_checksum (io_checksum)
`endif
    );

    always #5 clock = ~clock;

    // One LFSR step computed from the polynomial exponents
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int   taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        for (int t = 0; t < 4; t++) begin
            fb = fb ^ v[taps[t] - 1];
        end
        return (v << 1) | {15'd0, fb};
    endfunction

    function automatic logic [VW-1:0] pick_syms(input int mode, input int cyc);
        if (mode == 1) return VW'(cyc);
        if (mode == 2) return 12'h0FF;
        return VW'($urandom);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic abort, input logic [15:0] num,
                                 input logic [7:0] skip, input logic [15:0] seed,
                                 input logic ready, input logic [VW-1:0] syms);
        io_start    = start;
        io_abort    = abort;
        io_num_data = num;
        io_skip     = skip;
        io_seed     = seed;
        io_rd_ready = ready;
        io_syms     = syms;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_txen"}, io_tx_enable, 0);
        checkOutput({tag, "_txdata"}, io_tx_data, 0);
        checkOutput({tag, "_valid"}, io_rd_valid, 0);
        checkOutput({tag, "_rddata"}, io_rd_data, 0);
        checkOutput({tag, "_busy"}, io_busy, 0);
        checkOutput({tag, "_done"}, io_done, 0);
        checkOutput({tag, "_ovf"}, io_overflow, 0);
    endtask

    // Full run: launch, warm-up, capture against the queue model, drain, done pulse.
    // ready_mode 0 holds ready low while capturing and reads continuously when draining;
    // ready_mode 1 toggles ready randomly throughout.
    task automatic run_vectors(input logic [15:0] num, input logic [7:0] skip,
                               input logic [15:0] seed, input int ready_mode, input int sym_mode);
        int            cyc = 0;
        int            guard = 0;
        logic          rdy;
        logic [VW-1:0] s;
        applyStimulus(1'b1, 1'b0, num, skip, seed, 1'b0, '0);
        tick();
        io_start = 1'b0;
        lfsr_m   = (seed == 16'd0) ? 16'hACE1 : seed;
        q_m.delete();
        ovf_m = 1'b0;
        cs_m  = 16'd0;
        checkOutput("launch_busy", io_busy, 1);
        for (int w = 0; w < int'(skip); w++) begin
            cyc++;
            checkOutput("warm_txen", io_tx_enable, 1);
            checkOutput("warm_txdata", io_tx_data, lfsr_m[DW-1:0]);
            checkOutput("warm_valid", io_rd_valid, 0);
            io_syms = pick_syms(sym_mode, cyc);
            tick();
            lfsr_m = lfsr_step(lfsr_m);
        end
        for (int i = 0; i < int'(num); i++) begin
            cyc++;
            if (i < 3) first_tx[i] = io_tx_data;
            checkOutput("cap_txen", io_tx_enable, 1);
            checkOutput("cap_txdata", io_tx_data, lfsr_m[DW-1:0]);
            checkOutput("cap_valid", io_rd_valid, (q_m.size() != 0));
            if (q_m.size() != 0) checkOutput("cap_rddata", io_rd_data, q_m[0]);
            checkOutput("cap_done", io_done, 0);
            rdy = (ready_mode == 1) ? 1'($urandom) : 1'b0;
            s   = pick_syms(sym_mode, cyc);
            io_rd_ready = rdy;
            io_syms     = s;
            if (rdy && q_m.size() != 0) void'(q_m.pop_front());
            if (q_m.size() < DP) begin
                q_m.push_back(s);
                cs_m = {cs_m[14:0], cs_m[15]} ^ 16'(s);
            end else begin
                ovf_m = 1'b1;
            end
            tick();
            lfsr_m = lfsr_step(lfsr_m);
        end
        io_rd_ready = 1'b0;
        checkOutput("drain_txen", io_tx_enable, 0);
        checkOutput("drain_txdata", io_tx_data, 0);
        checkOutput("drain_ovf", io_overflow, ovf_m);
        checkOutput("drain_busy", io_busy, 1);
`ifdef SYM_CAPTURE_CHECKSUM_EN
        checkOutput("drain_checksum", io_checksum, cs_m);
`endif
        while (q_m.size() != 0 && guard < 200) begin
            checkOutput("drain_valid", io_rd_valid, 1);
            checkOutput("drain_rddata", io_rd_data, q_m[0]);
            checkOutput("drain_done", io_done, 0);
            rdy = (ready_mode == 1) ? 1'($urandom) : 1'b1;
            io_rd_ready = rdy;
            if (rdy) void'(q_m.pop_front());
            tick();
            guard++;
        end
        if (guard >= 200) checkOutput("drain_timeout", q_m.size(), 0);
        io_rd_ready = 1'b0;
        checkOutput("done_pulse", io_done, 1);
        checkOutput("done_valid", io_rd_valid, 0);
        checkOutput("done_busy", io_busy, 1);
        checkOutput("done_txen", io_tx_enable, 0);
        tick();
        checkOutput("after_done", io_done, 0);
        checkOutput("after_busy", io_busy, 0);
        checkOutput("after_ovf", io_overflow, ovf_m);
    endtask

    initial begin
        logic [15:0] s16;

        // Reset values while reset is held
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd0, 16'd0, 1'b0, '0);
        #12;
        check_all_zero("reset");
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("idle");

        // Zero seed falls back to the default; three vectors held with ready low
        run_vectors(16'd3, 8'd0, 16'd0, 0, 0);
        checkOutput("seed0_first_tx", first_tx[0], 32'hE1);

        // Two warm-up cycles, ramped symbols: only cycles 3..6 are captured
        run_vectors(16'd4, 8'd2, 16'h1234, 0, 1);

        // Six vectors into four slots with no reads: overflow, first four kept
        run_vectors(16'd6, 8'd0, 16'hBEEF, 0, 0);

        // Randomised runs with random read pressure
        for (int r = 0; r < 6; r++) begin
            s16 = 16'($urandom);
            run_vectors(16'($urandom_range(1, 12)), 8'($urandom_range(0, 4)), s16, 1, 0);
        end

        // Empty run goes straight to DONE without enabling the encoder
        applyStimulus(1'b1, 1'b0, 16'd0, 8'd3, 16'h0042, 1'b0, '0);
        tick();
        io_start = 1'b0;
        checkOutput("zero_done", io_done, 1);
        checkOutput("zero_txen", io_tx_enable, 0);
        checkOutput("zero_busy", io_busy, 1);
        tick();
        checkOutput("zero_done_end", io_done, 0);
        checkOutput("zero_busy_end", io_busy, 0);
        checkOutput("zero_txen_end", io_tx_enable, 0);

        // Abort after five capture writes (fifth overflows); start pulses mid-run are ignored
        s16 = 16'($urandom);
        applyStimulus(1'b1, 1'b0, 16'd10, 8'd0, s16, 1'b0, '0);
        tick();
        io_start = 1'b0;
        lfsr_m   = (s16 == 16'd0) ? 16'hACE1 : s16;
        for (int i = 0; i < 5; i++) begin
            checkOutput("abort_txdata", io_tx_data, lfsr_m[DW-1:0]);
            io_syms = VW'($urandom);
            if (i >= 1) begin
                io_start = 1'b1;
                io_seed  = 16'($urandom);
            end
            tick();
            lfsr_m = lfsr_step(lfsr_m);
        end
        checkOutput("abort_pre_ovf", io_overflow, 1);
        checkOutput("abort_pre_valid", io_rd_valid, 1);
        checkOutput("abort_pre_txdata", io_tx_data, lfsr_m[DW-1:0]);
        applyStimulus(1'b0, 1'b1, 16'd10, 8'd0, 16'd0, 1'b0, '0);
        tick();
        io_abort = 1'b0;
        checkOutput("abort_busy", io_busy, 0);
        checkOutput("abort_valid", io_rd_valid, 0);
        checkOutput("abort_done", io_done, 0);
        checkOutput("abort_txen", io_tx_enable, 0);
        checkOutput("abort_ovf_kept", io_overflow, 1);
        tick();
        checkOutput("abort_done_late", io_done, 0);
        checkOutput("abort_valid_late", io_rd_valid, 0);

        // Reset asserted while draining wipes everything at once
        applyStimulus(1'b1, 1'b0, 16'd3, 8'd0, 16'h5A5A, 1'b0, '0);
        tick();
        io_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            io_syms = VW'($urandom);
            tick();
        end
        checkOutput("drain_rst_busy", io_busy, 1);
        checkOutput("drain_rst_valid", io_rd_valid, 1);
        io_rd_ready = 1'b1;
        reset = 1'b1;
        #1;
        check_all_zero("mid_drain_reset");
        tick();
        reset = 1'b0;
        io_rd_ready = 1'b0;
        tick();
        checkOutput("post_reset_done", io_done, 0);
        checkOutput("post_reset_valid", io_rd_valid, 0);

`ifdef SYM_CAPTURE_CHECKSUM_EN
        // Constant 12'h0FF over two vectors gives 16'h0101, held after the run
        run_vectors(16'd2, 8'd0, 16'h0001, 0, 2);
        checkOutput("checksum_const", io_checksum, 32'h0101);
`endif

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
